// File: rtl/spart_pkg.sv
// Shared constants for the SPART bus responder: register map, status bit layout and TX state encoding.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  localparam int ST_TBR    = 0;
  localparam int ST_RDA    = 1;
  localparam int ST_TX_OVR = 2;
  localparam int ST_RX_OVR = 3;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_t;

  function automatic logic [7:0] pack_status(input logic tbr_f, input logic rda_f,
                                             input logic tx_ovr_f, input logic rx_ovr_f);
    logic [7:0] s;
    s            = 8'h00;
    s[ST_TBR]    = tbr_f;
    s[ST_RDA]    = rda_f;
    s[ST_TX_OVR] = tx_ovr_f;
    s[ST_RX_OVR] = rx_ovr_f;
    return s;
  endfunction

endpackage

// File: rtl/spart_rx_fifo.sv
// Small RX byte queue; the head is visible combinationally so a bus read returns it in the same cycle.
module spart_rx_fifo #(
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(RX_DEPTH);

  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push onto a full queue still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/spart_bus_slave.sv
// SPART bus responder: register decode, baud tick generator, one-byte TX holding register, RX queue.
// Define SPART_DIV_READBACK_EN to make the divisor bytes readable at addresses 10/11.
module spart_bus_slave
  import spart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd325,
  parameter int          RX_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       tbr,
  output logic       rda,
  output logic       baud_en,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_valid
);

  logic bus_wr, bus_rd;
  logic wr_data, wr_div_lo, wr_div_hi, wr_div;
  logic rd_data, rd_status;

  assign bus_wr    = iocs && !iorw;
  assign bus_rd    = iocs && iorw;
  assign wr_data   = bus_wr && (ioaddr == ADDR_DATA);
  assign wr_div_lo = bus_wr && (ioaddr == ADDR_DIV_LO);
  assign wr_div_hi = bus_wr && (ioaddr == ADDR_DIV_HI);
  assign wr_div    = wr_div_lo || wr_div_hi;
  assign rd_data   = bus_rd && (ioaddr == ADDR_DATA);
  assign rd_status = bus_rd && (ioaddr == ADDR_STATUS);

  // Baud generator
  logic [15:0] div_reg, div_next;
  logic [15:0] cnt_reg;

  always_comb begin
    div_next = div_reg;
    if (wr_div_lo) div_next[7:0]  = databus;
    if (wr_div_hi) div_next[15:8] = databus;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= DEFAULT_DIV;
      cnt_reg <= DEFAULT_DIV;
    end else begin
      div_reg <= div_next;
      if (wr_div)              cnt_reg <= div_next;
      else if (cnt_reg == '0)  cnt_reg <= div_reg;
      else                     cnt_reg <= cnt_reg - 16'd1;
    end
  end

  // A divisor write restarts the period, so the stale tick is swallowed.
  assign baud_en = (cnt_reg == '0) && !wr_div;

  // TX holding register
  tx_state_t  tx_state_reg, tx_state_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic       tx_ovr_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= TX_EMPTY;
      tx_data_reg  <= 8'h00;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_data_next  = tx_data_reg;
    tx_start      = 1'b0;
    tx_ovr_set    = 1'b0;
    case (tx_state_reg)
      TX_EMPTY: begin
        if (wr_data) begin
          tx_data_next  = databus;
          tx_state_next = TX_FULL;
        end
      end
      TX_FULL: begin
        tx_ovr_set = wr_data;
        if (!tx_busy) begin
          tx_start      = 1'b1;
          tx_state_next = TX_EMPTY;
        end
      end
      default: tx_state_next = TX_EMPTY;
    endcase
  end

  assign tbr     = (tx_state_reg == TX_EMPTY);
  assign tx_data = tx_data_reg;

  // RX queue
  logic [7:0] rx_head;
  logic       rx_full, rx_empty;
  logic       rx_ovr_set;

  spart_rx_fifo #(
    .RX_DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rx_valid),
    .pop  (rd_data),
    .din  (rx_data),
    .head (rx_head),
    .full (rx_full),
    .empty(rx_empty)
  );

  assign rda        = !rx_empty;
  assign rx_ovr_set = rx_valid && rx_full && !rd_data;

  // Sticky overrun flags: a status read clears them, a fresh overrun in that cycle wins.
  logic tx_ovr_reg, rx_ovr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovr_reg <= 1'b0;
      rx_ovr_reg <= 1'b0;
    end else begin
      tx_ovr_reg <= (tx_ovr_reg && !rd_status) || tx_ovr_set;
      rx_ovr_reg <= (rx_ovr_reg && !rd_status) || rx_ovr_set;
    end
  end

  // Read mux
  logic [7:0] rd_byte;

  always_comb begin
    rd_byte = 8'h00;
    case (ioaddr)
      ADDR_DATA:   rd_byte = rx_empty ? 8'h00 : rx_head;
      ADDR_STATUS: rd_byte = pack_status(tbr, rda, tx_ovr_reg, rx_ovr_reg);
`ifdef SPART_DIV_READBACK_EN
      ADDR_DIV_LO: rd_byte = div_reg[7:0];
      ADDR_DIV_HI: rd_byte = div_reg[15:8];
`endif
      default:     rd_byte = 8'h00;
    endcase
  end

  assign databus = bus_rd ? rd_byte : 8'hzz;

endmodule

// File: tb/tb_spart_bus_slave.sv
// Randomised and directed bench for spart_bus_slave against a queue-based behavioural model.
module tb_spart_bus_slave;

  localparam logic [15:0] DEF_DIV = 16'd325;
  localparam int          DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0, iorw = 1'b0, rx_valid = 1'b0, tx_busy = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] wdata = 8'h00, rx_data = 8'h00;
  wire  [7:0] databus;
  logic       tbr, rda, baud_en, tx_start;
  logic [7:0] tx_data;

  assign databus = (iocs && !iorw) ? wdata : 8'hzz;

  always #5 clk = ~clk;

  spart_bus_slave #(
    .DEFAULT_DIV(DEF_DIV),
    .RX_DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .tbr     (tbr),
    .rda     (rda),
    .baud_en (baud_en),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_busy (tx_busy),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: byte queue, TX full flag, divisor and phase within the baud period
  logic [7:0]  m_q[$];
  logic        m_full;
  logic [7:0]  m_txd;
  logic        m_txo, m_rxo;
  logic [15:0] m_div;
  int          m_k;

  logic [7:0] last_rd;
  logic       last_baud, last_start, last_tbr, last_rda;
  logic       busy_g = 1'b0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_full = 1'b0;
    m_txd  = 8'h00;
    m_txo  = 1'b0;
    m_rxo  = 1'b0;
    m_div  = DEF_DIV;
    m_k    = 0;
  endtask

  function automatic logic [7:0] exp_read(input logic [1:0] a);
    case (a)
      2'd0:    return (m_q.size() != 0) ? m_q[0] : 8'h00;
      2'd1:    return {4'b0000, m_rxo, m_txo, m_q.size() != 0, !m_full};
`ifdef SPART_DIV_READBACK_EN
      2'd2:    return m_div[7:0];
      default: return m_div[15:8];
`else
      default: return 8'h00;
`endif
    endcase
  endfunction

  task automatic cyc(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] wd,
                     input logic rv, input logic [7:0] rin, input logic busy);
    logic wr_div, wr_tx, rd_st, pop, new_txo, new_rxo;
    iocs = cs; iorw = rw; ioaddr = a; wdata = wd;
    rx_valid = rv; rx_data = rin; tx_busy = busy;
    @(negedge clk);
    wr_div = cs && !rw && a[1];
    check_val("tbr", {15'd0, tbr}, {15'd0, !m_full});
    check_val("rda", {15'd0, rda}, {15'd0, m_q.size() != 0});
    check_val("tx_start", {15'd0, tx_start}, {15'd0, m_full && !busy});
    check_val("tx_data", {8'd0, tx_data}, {8'd0, m_txd});
    check_val("baud_en", {15'd0, baud_en}, {15'd0, (m_k == int'(m_div)) && !wr_div});
    if (cs && rw) check_val("rdata", {8'd0, databus}, {8'd0, exp_read(a)});
    last_rd = databus; last_baud = baud_en; last_start = tx_start;
    last_tbr = tbr; last_rda = rda;
    if (cs) $display("txn %s addr=%0d data=%h rxv=%0d busy=%0d", rw ? "rd" : "wr", a,
                     rw ? databus : wd, rv, busy);
    @(posedge clk);
    wr_tx = cs && !rw && (a == 2'd0);
    rd_st = cs && rw && (a == 2'd1);
    pop   = cs && rw && (a == 2'd0) && (m_q.size() != 0);
    new_txo = 1'b0;
    new_rxo = 1'b0;
    if (wr_div) begin
      if (a[0]) m_div[15:8] = wd;
      else      m_div[7:0]  = wd;
      m_k = 0;
    end else if (m_k == int'(m_div)) m_k = 0;
    else m_k++;
    if (m_full) begin
      if (wr_tx) new_txo = 1'b1;
      if (!busy) m_full = 1'b0;
    end else if (wr_tx) begin
      m_full = 1'b1;
      m_txd  = wd;
    end
    if (pop) void'(m_q.pop_front());
    if (rv) begin
      if (m_q.size() < DEPTH) m_q.push_back(rin);
      else new_rxo = 1'b1;
    end
    m_txo = (m_txo && !rd_st) || new_txo;
    m_rxo = (m_rxo && !rd_st) || new_rxo;
    #1;
  endtask

  task automatic idle();                          cyc(0, 0, 2'd0, 8'h00, 0, 8'h00, busy_g); endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d); cyc(1, 0, a, d, 0, 8'h00, busy_g); endtask
  task automatic rd(input logic [1:0] a);         cyc(1, 1, a, 8'h00, 0, 8'h00, busy_g); endtask
  task automatic push(input logic [7:0] d);       cyc(0, 0, 2'd0, 8'h00, 1, d, busy_g); endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      idle();
      n++;
    end while (!last_baud && n < 2000);
  endtask

  initial begin
    int n;
    logic cs, rw;
    logic [1:0] a;
    logic [7:0] d;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and divisor readback
    rd(2'd1); check_val("rst_status", {8'd0, last_rd}, 16'h0001);
    rd(2'd2);
`ifdef SPART_DIV_READBACK_EN
    check_val("rst_div_lo", {8'd0, last_rd}, 16'h0045);
`else
    check_val("rst_div_lo", {8'd0, last_rd}, 16'h0000);
`endif
    rd(2'd3);
`ifdef SPART_DIV_READBACK_EN
    check_val("rst_div_hi", {8'd0, last_rd}, 16'h0001);
`else
    check_val("rst_div_hi", {8'd0, last_rd}, 16'h0000);
`endif
    wait_tick(n);
    wait_tick(n); check_val("period_326", n[15:0], 16'd326);

    // New divisor takes effect right after the high byte write
    wr(2'd2, 8'h28);
    wr(2'd3, 8'h00);
    wait_tick(n); check_val("first_41", n[15:0], 16'd41);
    wait_tick(n); check_val("period_41", n[15:0], 16'd41);

    // TX with idle transmitter
    busy_g = 1'b0;
    wr(2'd0, 8'h55);
    idle();
    check_val("tx_tbr_low", {15'd0, last_tbr}, 16'd0);
    check_val("tx_start_hi", {15'd0, last_start}, 16'd1);
    check_val("tx_data_55", {8'd0, tx_data}, 16'h0055);
    idle();
    check_val("tx_start_lo", {15'd0, last_start}, 16'd0);
    check_val("tx_tbr_back", {15'd0, last_tbr}, 16'd1);

    // TX overrun while transmitter busy
    busy_g = 1'b1;
    wr(2'd0, 8'hA1);
    wr(2'd0, 8'hB2);
    idle();
    check_val("tx_hold_A1", {8'd0, tx_data}, 16'h00A1);
    rd(2'd1); check_val("status_04", {8'd0, last_rd}, 16'h0004);
    busy_g = 1'b0;
    idle(); check_val("release_start", {15'd0, last_start}, 16'd1);
    idle(); check_val("release_once", {15'd0, last_start}, 16'd0);
    rd(2'd1); check_val("status_01", {8'd0, last_rd}, 16'h0001);

    // RX overrun and drain
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    rd(2'd1); check_val("status_0B", {8'd0, last_rd}, 16'h000B);
    for (int i = 0; i < 4; i++) begin
      rd(2'd0); check_val("rx_pop", {8'd0, last_rd}, 16'h0010 + 16'(i));
    end
    idle(); check_val("rx_empty_rda", {15'd0, last_rda}, 16'd0);
    rd(2'd0); check_val("rx_empty_rd", {8'd0, last_rd}, 16'h0000);

    // Full queue with simultaneous pop and push
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
    cyc(1, 1, 2'd0, 8'h00, 1, 8'h24, 1'b0);
    check_val("full_popush", {8'd0, last_rd}, 16'h0020);
    rd(2'd1); check_val("no_rx_ovr", {8'd0, last_rd}, 16'h0003);
    for (int i = 0; i < 4; i++) begin
      rd(2'd0); check_val("full_drain", {8'd0, last_rd}, 16'h0021 + 16'(i));
    end
    idle(); check_val("full_drained", {15'd0, last_rda}, 16'd0);

    // Reset mid-operation discards pending work
    busy_g = 1'b1;
    wr(2'd0, 8'h77);
    push(8'h31);
    push(8'h32);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    busy_g = 1'b0;
    idle();
    check_val("mid_rst_start", {15'd0, last_start}, 16'd0);
    check_val("mid_rst_tbr", {15'd0, last_tbr}, 16'd1);
    check_val("mid_rst_rda", {15'd0, last_rda}, 16'd0);
    check_val("mid_rst_txd", {8'd0, tx_data}, 16'h0000);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      cs = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      a  = 2'($urandom_range(0, 3));
      if (a == 2'd3)      d = 8'h00;
      else if (a == 2'd2) d = 8'($urandom_range(0, 12));
      else                d = 8'($urandom);
      cyc(cs, rw, a, d, ($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
